ctrl_mem_load: RTL and testbench

Input-side control stage of the convolution datapath. It accepts the x vector and the f vector over two independent AXI-stream-style valid/ready inputs and writes them into the x and f memories. Once both memories are full, it raises `conv_start` to the output controller. It holds off new input until that controller returns `conv_done`, then re-arms for the next vector pair.

---
 rtl/conv_pkg.sv | 16 +
 rtl/ctrl_stream_fill.sv | 48 ++++
 rtl/ctrl_mem_load.sv | 115 +++++++++++
 tb/tb_ctrl_mem_load.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution control stages
// (input loader and output controller).
package conv_pkg;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    CONV = 1'b1
  } ctrl_load_state_t;

  localparam int DEF_X_MEM_SIZE       = 8;
  localparam int DEF_F_MEM_SIZE       = 4;
  localparam int DEF_X_MEM_ADDR_WIDTH = 3;
  localparam int DEF_F_MEM_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH       = 8;

endpackage

// File: rtl/ctrl_stream_fill.sv
// Fill counter for one valid/ready input stream: accepts words while enabled
// and not yet full, and produces the memory write address for each accepted word.
module ctrl_stream_fill #(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              enable,
  input  logic              clear,
  output logic              ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              full
);

  localparam logic [ADDR_W:0] SIZE_C = (ADDR_W + 1)'(SIZE);

  logic [ADDR_W:0] cnt_q;
  logic [ADDR_W:0] cnt_d;

  // Ready depends only on registered state; full reports the count after this edge
  // so the parent can leave LOAD with zero bubble.
  always_comb begin
    ready   = enable && (cnt_q < SIZE_C);
    wr_en   = valid && ready;
    wr_addr = cnt_q[ADDR_W-1:0];
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wr_en) begin
      cnt_d = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    full = (cnt_d == SIZE_C);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_mem_load.sv
// Input-side control of the convolution datapath: loads the x and f memories
// from two independent streams, then holds in CONV until conv_done.
module ctrl_mem_load
  import conv_pkg::*;
#(
  parameter int X_MEM_SIZE       = DEF_X_MEM_SIZE,
  parameter int F_MEM_SIZE       = DEF_F_MEM_SIZE,
  parameter int X_MEM_ADDR_WIDTH = DEF_X_MEM_ADDR_WIDTH,
  parameter int F_MEM_ADDR_WIDTH = DEF_F_MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       s_data_in_x,
  input  logic                        s_valid_x,
  output logic                        s_ready_x,
  input  logic [DATA_WIDTH-1:0]       s_data_in_f,
  input  logic                        s_valid_f,
  output logic                        s_ready_f,
  output logic                        x_wr_en,
  output logic [X_MEM_ADDR_WIDTH-1:0] x_wr_addr,
  output logic [DATA_WIDTH-1:0]       x_wr_data,
  output logic                        f_wr_en,
  output logic [F_MEM_ADDR_WIDTH-1:0] f_wr_addr,
  output logic [DATA_WIDTH-1:0]       f_wr_data,
  input  logic                        conv_done,
  output logic                        conv_start
);

  ctrl_load_state_t state_q;
  ctrl_load_state_t state_d;
  logic             conv_start_q;
  logic             conv_start_d;
  logic             load_en;
  logic             clear_cnt;
  logic             x_full;
  logic             f_full;

  ctrl_stream_fill #(
    .SIZE   (X_MEM_SIZE),
    .ADDR_W (X_MEM_ADDR_WIDTH)
  ) u_fill_x (
    .clk     (clk),
    .reset   (reset),
    .valid   (s_valid_x),
    .enable  (load_en),
    .clear   (clear_cnt),
    .ready   (s_ready_x),
    .wr_en   (x_wr_en),
    .wr_addr (x_wr_addr),
    .full    (x_full)
  );

  ctrl_stream_fill #(
    .SIZE   (F_MEM_SIZE),
    .ADDR_W (F_MEM_ADDR_WIDTH)
  ) u_fill_f (
    .clk     (clk),
    .reset   (reset),
    .valid   (s_valid_f),
    .enable  (load_en),
    .clear   (clear_cnt),
    .ready   (s_ready_f),
    .wr_en   (f_wr_en),
    .wr_addr (f_wr_addr),
    .full    (f_full)
  );

  assign x_wr_data  = s_data_in_x;
  assign f_wr_data  = s_data_in_f;
  assign conv_start = conv_start_q;

  // Next-state decode; conv_done only matters while in CONV.
  always_comb begin
    load_en      = (state_q == LOAD);
    clear_cnt    = (state_q == CONV) && conv_done;
    state_d      = state_q;
    conv_start_d = conv_start_q;
    case (state_q)
      LOAD: begin
        if (x_full && f_full) begin
          state_d      = CONV;
          conv_start_d = 1'b1;
        end else begin
          state_d      = LOAD;
          conv_start_d = 1'b0;
        end
      end
      CONV: begin
        if (conv_done) begin
          state_d      = LOAD;
          conv_start_d = 1'b0;
        end else begin
          state_d      = CONV;
          conv_start_d = 1'b1;
        end
      end
      default: begin
        state_d      = LOAD;
        conv_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LOAD;
      conv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_start_q <= conv_start_d;
    end
  end

endmodule

// File: tb/tb_ctrl_mem_load.sv
// Directed bench for ctrl_mem_load: a cycle model predicts readies/conv_start,
// and a scoreboard of expected (addr, data) writes is checked by a monitor.
module tb_ctrl_mem_load;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data_in_x;
  logic       s_valid_x;
  logic       s_ready_x;
  logic [7:0] s_data_in_f;
  logic       s_valid_f;
  logic       s_ready_f;
  logic       x_wr_en;
  logic [2:0] x_wr_addr;
  logic [7:0] x_wr_data;
  logic       f_wr_en;
  logic [1:0] f_wr_addr;
  logic [7:0] f_wr_data;
  logic       conv_done;
  logic       conv_start;

  ctrl_mem_load dut (
    .clk         (clk),
    .reset       (reset),
    .s_data_in_x (s_data_in_x),
    .s_valid_x   (s_valid_x),
    .s_ready_x   (s_ready_x),
    .s_data_in_f (s_data_in_f),
    .s_valid_f   (s_valid_f),
    .s_ready_f   (s_ready_f),
    .x_wr_en     (x_wr_en),
    .x_wr_addr   (x_wr_addr),
    .x_wr_data   (x_wr_data),
    .f_wr_en     (f_wr_en),
    .f_wr_addr   (f_wr_addr),
    .f_wr_data   (f_wr_data),
    .conv_done   (conv_done),
    .conv_start  (conv_start)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] xq[$];
  logic [9:0]  fq[$];
  logic [10:0] ex;
  logic [9:0]  ef;
  int          mstate;
  int          mx;
  int          mf;
  logic        mstart;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstate = 0;
    mx     = 0;
    mf     = 0;
    mstart = 1'b0;
  endtask

  // One clock cycle: drive, predict, check mid-cycle, then advance the model.
  task automatic step(input logic vx, input logic [7:0] dx, input logic vf,
                      input logic [7:0] df, input logic done);
    logic rx;
    logic rf;
    s_valid_x   = vx;
    s_data_in_x = dx;
    s_valid_f   = vf;
    s_data_in_f = df;
    conv_done   = done;
    rx = (mstate == 0) && (mx < 8);
    rf = (mstate == 0) && (mf < 4);
    if (vx && rx) xq.push_back({mx[2:0], dx});
    if (vf && rf) fq.push_back({mf[1:0], df});
    @(negedge clk);
    chk("s_ready_x", s_ready_x, rx);
    chk("s_ready_f", s_ready_f, rf);
    chk("conv_start", conv_start, mstart);
    chk("x_wr_en", x_wr_en, vx && rx);
    chk("f_wr_en", f_wr_en, vf && rf);
    @(posedge clk);
    if (mstate == 0) begin
      mx = mx + ((vx && rx) ? 1 : 0);
      mf = mf + ((vf && rf) ? 1 : 0);
      if (mx == 8 && mf == 4) begin
        mstate = 1;
        mstart = 1'b1;
      end
    end else if (done) begin
      model_reset();
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (x_wr_en === 1'b1 && xq.size() > 0) begin
        ex = xq.pop_front();
        chk("x_wr_addr", x_wr_addr, ex[10:8]);
        chk("x_wr_data", x_wr_data, ex[7:0]);
      end
      if (f_wr_en === 1'b1 && fq.size() > 0) begin
        ef = fq.pop_front();
        chk("f_wr_addr", f_wr_addr, ef[9:8]);
        chk("f_wr_data", f_wr_data, ef[7:0]);
      end
    end
  end

  initial begin
    reset       = 1'b0;
    s_valid_x   = 1'b0;
    s_valid_f   = 1'b0;
    s_data_in_x = 8'h00;
    s_data_in_f = 8'h00;
    conv_done   = 1'b0;
    model_reset();
    #8;
    chk("rst_ready_x", s_ready_x, 1'b1);
    chk("rst_ready_f", s_ready_f, 1'b1);
    chk("rst_conv_start", conv_start, 1'b0);
    chk("rst_x_wr_en", x_wr_en, 1'b0);
    chk("rst_f_wr_en", f_wr_en, 1'b0);
    #4 reset = 1'b1;
    @(posedge clk);
    #1;

    // Both streams back to back, x = 1..8, f = 1..4.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i + 1), (i < 4), 8'(i + 1), 1'b0);
    // CONV hold with valid high and no conv_done.
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Second pair: f delayed 10 cycles; conv_done pulsed during LOAD is ignored.
    for (int c = 0; c < 18; c++)
      step((c < 10), 8'(8'h40 + c), (c >= 10 && c < 14), 8'(8'h80 + c), (c >= 3 && c <= 5));
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Random 50% valid gaps on both streams, bounded.
    for (int n = 0; n < 300 && mstate == 0; n++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rand_loaded", conv_start, 1'b1);
    chk("rand_xq_drained", xq.size(), 32'd0);
    chk("rand_fq_drained", fq.size(), 32'd0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset after 5 x words.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b0);
    s_valid_x = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_conv_start", conv_start, 1'b0);
    chk("async_ready_x", s_ready_x, 1'b1);
    chk("async_x_addr", x_wr_addr, 3'd0);
    chk("async_f_addr", f_wr_addr, 2'd0);
    model_reset();
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'hC0 + i), (i < 4), 8'(8'hD0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hC7, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    chk("end_xq_empty", xq.size(), 32'd0);
    chk("end_fq_empty", fq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
